// File: rtl/mul_pipe_pkg.sv
// Shared constants, result record and helpers for the mul_pipe multiplier stage.
package mul_pipe_pkg;

  localparam int DATA_W     = 16;
  // Record tag field is sized for the widest supported AW; mul_pipe uses the low AW bits.
  localparam int ADDR_MAX_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0]     p;
    logic [ADDR_MAX_W-1:0] addr;
    logic                  zero;
    logic                  ovf;
  } res_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/mul_pipe_core.sv
// Combinational 16x16 unsigned low-product datapath with optional overflow flag.
// MUL_PIPE_OVF_EN adds the upper-product overflow detection.
module mul_pipe_core
  import mul_pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p,
  output logic              zero,
  output logic              ovf
);

`ifdef MUL_PIPE_OVF_EN
  logic [2*DATA_W-1:0] full;

  function automatic logic [DATA_W-1:0] trunc_lo(input logic [2*DATA_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction

  function automatic logic ovf_hi(input logic [2*DATA_W-1:0] v);
    return |v[2*DATA_W-1:DATA_W];
  endfunction

  assign full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign p    = trunc_lo(full);
  assign ovf  = ovf_hi(full);
`else
  // Only the low half is ever formed, so no upper-product logic exists in this build.
  assign p    = a * b;
  assign ovf  = 1'b0;
`endif

  assign zero = is_zero(p);

endmodule

// File: rtl/mul_pipe.sv
// Two-stage valid/ready multiplier pipe: S1 holds operands+tag, S2 holds the result record.
// Build with MUL_PIPE_OVF_EN to report overflow of the full 32-bit product on p_ovf.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [AW-1:0]     rd_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] p,
  output logic [AW-1:0]     p_addr,
  output logic              p_zero,
  output logic              p_ovf,
  input  logic [AW-1:0]     chk_addr,
  output logic              chk_hit
);

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [AW-1:0]     addr_p1;

  logic              vld_p2;
  res_t              res_p2;

  logic [DATA_W-1:0] prod;
  logic              prod_zero;
  logic              prod_ovf;
  res_t              core_res;
  logic              adv2;
  logic              unused_addr;

  mul_pipe_core u_core (
    .a    (a_p1),
    .b    (b_p1),
    .p    (prod),
    .zero (prod_zero),
    .ovf  (prod_ovf)
  );

  assign core_res = '{p: prod, addr: ADDR_MAX_W'(addr_p1), zero: prod_zero, ovf: prod_ovf};

  assign adv2     = !vld_p2 || out_ready;
  assign in_ready = !flush && (!vld_p1 || adv2);

  // ---- S1 (operands) -> S2 (result) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      addr_p1 <= '0;
      res_p2  <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (vld_p1 && adv2) begin
        vld_p2 <= 1'b1;
        res_p2 <= core_res;
      end else if (out_ready) begin
        vld_p2 <= 1'b0;
      end
      if (in_valid && in_ready) begin
        vld_p1  <= 1'b1;
        a_p1    <= rs_data;
        b_p1    <= rd_data;
        addr_p1 <= rd_addr;
      end else if (adv2) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign p           = res_p2.p;
  assign p_addr      = res_p2.addr[AW-1:0];
  assign p_zero      = res_p2.zero;
  assign p_ovf       = res_p2.ovf;
  assign unused_addr = ^res_p2.addr;

  assign chk_hit = !flush && ((vld_p1 && (addr_p1 == chk_addr)) ||
                              (vld_p2 && (p_addr == chk_addr)));

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: queue-based reference model plus directed literal checks.
module tb_mul_pipe;

  localparam int AW = 3;
`ifdef MUL_PIPE_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   rs_data = '0;
  logic [15:0]   rd_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] chk_addr = '0;
  logic          in_ready, out_valid, p_zero, p_ovf, chk_hit;
  logic [15:0]   p;
  logic [AW-1:0] p_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_pipe #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rd_data(rd_data), .rd_addr(rd_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .p_addr(p_addr),
    .p_zero(p_zero), .p_ovf(p_ovf), .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0]   p;
    logic [AW-1:0] addr;
    logic          zero;
    logic          ovf;
    int            age;
  } ent_t;

  ent_t q[$];

  function automatic ent_t mk(input logic [15:0] a, input logic [15:0] b, input logic [AW-1:0] t);
    ent_t e;
    logic [31:0] full;
    full   = 32'(a) * 32'(b);
    e.p    = full[15:0];
    e.addr = t;
    e.zero = (full[15:0] == 16'h0000);
    e.ovf  = OVF && (full > 32'h0000FFFF);
    e.age  = 0;
    return e;
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].age > 0);
  endfunction

  function automatic bit m_ready();
    return !flush && ((q.size() < 2) || out_ready);
  endfunction

  function automatic bit m_hit();
    bit h;
    h = 1'b0;
    foreach (q[i]) if (q[i].addr == chk_addr) h = 1'b1;
    return !flush && h;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit push;
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      push = in_valid && m_ready();
      if (m_valid() && out_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (push) q.push_back(mk(rs_data, rd_data, rd_addr));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(m_valid()));
      check("in_ready", 32'(in_ready), 32'(m_ready()));
      check("chk_hit", 32'(chk_hit), 32'(m_hit()));
      if (m_valid()) begin
        check("p", 32'(p), 32'(q[0].p));
        check("p_addr", 32'(p_addr), 32'(q[0].addr));
        check("p_zero", 32'(p_zero), 32'(q[0].zero));
        check("p_ovf", 32'(p_ovf), 32'(q[0].ovf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [AW-1:0] t);
    in_valid = 1'b1;
    rs_data  = a;
    rd_data  = b;
    rd_addr  = t;
  endtask

  task automatic issue_check(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [AW-1:0] t, input logic [15:0] ep,
                             input logic ez, input logic eo);
    step();
    out_ready = 1'b1;
    drive(a, b, t);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " p"}, 32'(p), 32'(ep));
    check({name, " p_addr"}, 32'(p_addr), 32'(t));
    check({name, " p_zero"}, 32'(p_zero), 32'(ez));
    check({name, " p_ovf"}, 32'(p_ovf), 32'(eo));
    step();
  endtask

  logic [15:0]   va [4] = '{16'h0002, 16'h0010, 16'h1234, 16'h8000};
  logic [15:0]   vb [4] = '{16'h0003, 16'h0010, 16'h0002, 16'h0002};
  logic [15:0]   vp [4] = '{16'h0006, 16'h0100, 16'h2468, 16'h0000};
  logic [15:0]   got_p[$];
  logic [AW-1:0] got_t[$];

  initial begin
    int idx;
    bit rdy;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst p", 32'(p), 32'd0);
    check("rst p_addr", 32'(p_addr), 32'd0);
    check("rst p_zero", 32'(p_zero), 32'd0);
    check("rst p_ovf", 32'(p_ovf), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after rst", 32'(in_ready), 32'd1);

    issue_check("mul3x5", 16'h0003, 16'h0005, 3'd2, 16'h000F, 1'b0, 1'b0);
    issue_check("mul100", 16'h0100, 16'h0100, 3'd3, 16'h0000, 1'b1, OVF);
    issue_check("mulFFFF", 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 1'b0, OVF);

    // backpressure: four back-to-back issues, out_ready low
    step();
    out_ready = 1'b0;
    idx = 0;
    drive(va[0], vb[0], 3'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) begin
        idx++;
        if (idx < 4) drive(va[idx], vb[idx], AW'(idx + 1));
      end
    end
    @(negedge clk);
    check("bp accepted", 32'(idx), 32'd2);
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp held p", 32'(p), 32'h0006);
    step();
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got_p.size() < 4; c++) begin
      @(negedge clk);
      rdy = in_ready;
      if (out_valid) begin
        got_p.push_back(p);
        got_t.push_back(p_addr);
      end
      step();
      if (in_valid && rdy) begin
        idx++;
        if (idx < 4) drive(va[idx], vb[idx], AW'(idx + 1));
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp delivered", 32'(got_p.size()), 32'd4);
    for (int i = 0; i < got_p.size() && i < 4; i++) begin
      check("bp order tag", 32'(got_t[i]), 32'(i + 1));
      check("bp order p", 32'(got_p[i]), 32'(vp[i]));
    end

    // hazard probe and flush
    step();
    out_ready = 1'b0;
    drive(16'h0004, 16'h0004, 3'd1);
    step();
    drive(16'h0005, 16'h0003, 3'd5);
    step();
    in_valid = 1'b0;
    chk_addr = 3'd5;
    @(negedge clk);
    check("hit tag5", 32'(chk_hit), 32'd1);
    step();
    chk_addr = 3'd1;
    @(negedge clk);
    check("hit tag1", 32'(chk_hit), 32'd1);
    step();
    chk_addr = 3'd6;
    @(negedge clk);
    check("miss tag6", 32'(chk_hit), 32'd0);
    step();
    chk_addr = 3'd5;
    flush = 1'b1;
    drive(16'h0009, 16'h0009, 3'd6);
    @(negedge clk);
    check("flush chk_hit", 32'(chk_hit), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post flush out_valid", 32'(out_valid), 32'd0);
    check("post flush chk_hit", 32'(chk_hit), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      check("dropped issue absent", 32'(out_valid), 32'd0);
    end

    // reset mid-operation with both stages full
    step();
    out_ready = 1'b0;
    drive(16'h0002, 16'h0002, 3'd2);
    step();
    drive(16'h0003, 16'h0003, 3'd3);
    step();
    in_valid = 1'b0;
    chk_addr = 3'd3;
    @(negedge clk);
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst p", 32'(p), 32'd0);
    check("mid rst p_addr", 32'(p_addr), 32'd0);
    check("mid rst p_zero", 32'(p_zero), 32'd0);
    check("mid rst p_ovf", 32'(p_ovf), 32'd0);
    check("mid rst chk_hit", 32'(chk_hit), 32'd0);
    step();
    step();
    rst = 1'b0;
    issue_check("after rst", 16'h0007, 16'h0009, 3'd4, 16'h003F, 1'b0, 1'b0);

    // mixed traffic against the model
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3) != 0;
      flush     = (i == 17);
      chk_addr  = AW'(i);
      in_valid  = (i % 5) != 4;
      rs_data   = 16'(i * 16'h0F0F + 7);
      rd_data   = 16'(16'hFFFF - i * 16'h0321);
      rd_addr   = AW'(i * 3);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
